vae_reparam_sampler: RTL and testbench



---
 rtl/vae_reparam_sampler.sv | 162 ++++++++++++++++
 tb/tb_vae_reparam_sampler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vae_reparam_sampler.sv
// VAE reparameterisation sampler: z = mu + sigma*eps in signed fixed point,
// requesting one noise sample per latent element and streaming z downstream.
module vae_reparam_sampler #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FRAC_BITS  = 12,
    parameter int unsigned LATENT_DIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] mu_in,
    input  logic [DATA_W-1:0] sigma_in,
    input  logic              eval_mode,
    output logic              gauss_en,
    input  logic [DATA_W-1:0] eps_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] z_out,
    output logic              out_last
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam int unsigned IDX_W  = (LATENT_DIM > 1) ? $clog2(LATENT_DIM) : 1;

    localparam logic signed [SUM_W-1:0] Z_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] Z_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(LATENT_DIM - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        MUL,
        OUT
    } state_e;

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] mu_q, mu_d;
    logic signed [DATA_W-1:0] sigma_q, sigma_d;
    logic signed [DATA_W-1:0] eps_q, eps_d;
    logic signed [DATA_W-1:0] z_q, z_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     eval_q, eval_d;
    logic                     in_ready_q, in_ready_d;
    logic                     gauss_q, gauss_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;

    logic signed [PROD_W-1:0] shifted;
    logic signed [SUM_W-1:0]  sum;
    logic signed [DATA_W-1:0] z_sat;

    // Floor-scaled product plus mu, saturated back to DATA_W
    always_comb begin
        shifted = prod_q >>> FRAC_BITS;
        sum     = SUM_W'(shifted) + SUM_W'(mu_q);
        if (sum > Z_MAX) begin
            z_sat = DATA_W'(Z_MAX);
        end else if (sum < Z_MIN) begin
            z_sat = DATA_W'(Z_MIN);
        end else begin
            z_sat = DATA_W'(sum);
        end
    end

    always_comb begin
        state_d    = state_q;
        mu_d       = mu_q;
        sigma_d    = sigma_q;
        eps_d      = eps_q;
        prod_d     = prod_q;
        eval_d     = eval_q;
        idx_d      = idx_q;
        z_d        = z_q;
        last_d     = last_q;
        in_ready_d = 1'b0;
        gauss_d    = 1'b0;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mu_d    = mu_in;
                    sigma_d = sigma_in[DATA_W-1] ? '0 : sigma_in;
                    eval_d  = eval_mode;
                    gauss_d = ~eval_mode;
                    state_d = REQ;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            REQ: begin
                state_d = CAPT;
            end
            CAPT: begin
                eps_d   = eval_q ? '0 : eps_in;
                state_d = MUL;
            end
            MUL: begin
                prod_d  = PROD_W'(sigma_q) * PROD_W'(eps_q);
                state_d = OUT;
            end
            OUT: begin
                // First OUT cycle loads the result register; then hold until taken
                if (!valid_q) begin
                    z_d     = z_sat;
                    last_d  = (idx_q == LAST_IDX);
                    valid_d = 1'b1;
                end else if (out_ready) begin
                    idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mu_q       <= '0;
            sigma_q    <= '0;
            eps_q      <= '0;
            prod_q     <= '0;
            eval_q     <= 1'b0;
            idx_q      <= '0;
            z_q        <= '0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
            gauss_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mu_q       <= mu_d;
            sigma_q    <= sigma_d;
            eps_q      <= eps_d;
            prod_q     <= prod_d;
            eval_q     <= eval_d;
            idx_q      <= idx_d;
            z_q        <= z_d;
            last_q     <= last_d;
            in_ready_q <= in_ready_d;
            gauss_q    <= gauss_d;
            valid_q    <= valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign gauss_en  = gauss_q;
    assign out_valid = valid_q;
    assign z_out     = z_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_vae_reparam_sampler.sv
// Directed bench for vae_reparam_sampler with hand-computed Q4.12 results.
module tb_vae_reparam_sampler;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] mu_in     = 16'h0000;
    logic [15:0] sigma_in  = 16'h0000;
    logic        eval_mode = 1'b0;
    logic        gauss_en;
    logic [15:0] eps_in    = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] z_out;
    logic        out_last;

    int total = 0;
    int bad   = 0;
    int gcnt  = 0;
    int viol  = 0;

    vae_reparam_sampler #(
        .DATA_W    (16),
        .FRAC_BITS (12),
        .LATENT_DIM(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mu_in    (mu_in),
        .sigma_in (sigma_in),
        .eval_mode(eval_mode),
        .gauss_en (gauss_en),
        .eps_in   (eps_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z_out    (z_out),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    // Protocol monitor: noise pulses and mutually exclusive phase signals
    always @(negedge clk) begin
        if (gauss_en) gcnt++;
        if (gauss_en && in_ready) viol++;
        if (gauss_en && out_valid) viol++;
        if (in_ready && out_valid) viol++;
        if (!rst && (gauss_en || out_valid || in_ready)) viol++;
    end

    task automatic wait_ready(input string nm);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready: got %b want 1", nm, in_ready);
        end
    endtask

    task automatic do_elem(input logic [15:0] mu, input logic [15:0] sg, input logic [15:0] ep,
                           input logic ev, input logic [15:0] exp_z, input logic exp_last,
                           input string nm);
        wait_ready(nm);
        mu_in = mu; sigma_in = sg; eval_mode = ev; eps_in = 16'h5A5A;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; eval_mode = ~ev; mu_in = 16'h0BAD; sigma_in = 16'h0BAD;
        total++;
        if (gauss_en !== ~ev) begin bad++; $display("FAIL %s gauss_en in REQ: got %b want %b", nm, gauss_en, ~ev); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL %s in_ready busy: got %b want 0", nm, in_ready); end
        @(posedge clk); #1;
        eps_in = ep;
        total++;
        if (gauss_en !== 1'b0) begin bad++; $display("FAIL %s gauss_en width: got %b want 0", nm, gauss_en); end
        @(posedge clk); #1;
        eps_in = 16'h3C3C;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL %s early valid e2: got %b want 0", nm, out_valid); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL %s early valid e3: got %b want 0", nm, out_valid); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL %s out_valid e4: got %b want 1", nm, out_valid); end
        total++;
        if (z_out !== exp_z) begin bad++; $display("FAIL %s z_out: got %h want %h", nm, z_out, exp_z); end
        total++;
        if (out_last !== exp_last) begin bad++; $display("FAIL %s out_last: got %b want %b", nm, out_last, exp_last); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL %s valid drop: got %b want 0", nm, out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL %s ready return: got %b want 1", nm, in_ready); end
        eval_mode = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        total++;
        if (gauss_en !== 1'b0) begin bad++; $display("FAIL reset gauss_en: got %b want 0", gauss_en); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        total++;
        if (z_out !== 16'h0000) begin bad++; $display("FAIL reset z_out: got %h want 0000", z_out); end
        total++;
        if (out_last !== 1'b0) begin bad++; $display("FAIL reset out_last: got %b want 0", out_last); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL release in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        do_elem(16'h1000, 16'h2000, 16'h0C00, 1'b0, 16'h2800, 1'b0, "pos_eps");
        do_elem(16'h1000, 16'h2000, 16'hF400, 1'b0, 16'hF800, 1'b0, "neg_eps");
        do_elem(16'h0000, 16'h0001, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, "floor");
    endtask

    task automatic test_saturate();
        do_elem(16'h7000, 16'h4000, 16'h0C00, 1'b0, 16'h7FFF, 1'b0, "sat_hi");
        do_elem(16'h9000, 16'h4000, 16'hF400, 1'b0, 16'h8000, 1'b0, "sat_lo");
        do_elem(16'h0ABC, 16'hF000, 16'h0C00, 1'b0, 16'h0ABC, 1'b0, "neg_sigma");
    endtask

    task automatic test_eval();
        int g0;
        g0 = gcnt;
        do_elem(16'h1234, 16'h2000, 16'h0C00, 1'b1, 16'h1234, 1'b0, "eval_a");
        do_elem(16'hEDCC, 16'h4000, 16'h7000, 1'b1, 16'hEDCC, 1'b1, "eval_last");
        total++;
        if (gcnt != g0) begin bad++; $display("FAIL eval gauss count: got %0d want %0d", gcnt, g0); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++)
            do_elem(16'h1000, 16'h2000, 16'h0C00, 1'b0, 16'h2800, 1'b0, "pre_reset");
        wait_ready("mid_accept");
        mu_in = 16'h1000; sigma_in = 16'h2000; eps_in = 16'h0C00; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst in_ready: got %b want 0", in_ready); end
        total++;
        if (z_out !== 16'h0000) begin bad++; $display("FAIL midrst z_out: got %h want 0000", z_out); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        do_elem(16'h1000, 16'h2000, 16'hF400, 1'b0, 16'hF800, 1'b0, "post_reset");
    endtask

    task automatic test_stream();
        int  g0;
        logic hs;
        logic done;
        logic [15:0] exp_z;
        logic exp_last;
        #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        g0 = gcnt;
        eps_in = 16'h0100;
        for (int i = 0; i < 16; i++) begin
            exp_z    = 16'((i + 1) * 256);
            exp_last = (i == 7) || (i == 15);
            wait_ready("stream_accept");
            mu_in = 16'(i * 256); sigma_in = 16'h1000; eval_mode = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            hs = 1'b0;
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                @(posedge clk); #1;
                if (hs) begin
                    done = 1'b1;
                    total++;
                    if (out_valid !== 1'b0) begin bad++; $display("FAIL stream %0d drop: got %b want 0", i, out_valid); end
                end else if (out_valid) begin
                    total++;
                    if (z_out !== exp_z) begin bad++; $display("FAIL stream %0d z_out: got %h want %h", i, z_out, exp_z); end
                    total++;
                    if (out_last !== exp_last) begin bad++; $display("FAIL stream %0d out_last: got %b want %b", i, out_last, exp_last); end
                    out_ready = (c > 30) ? 1'b1 : 1'($urandom_range(0, 1));
                    hs = out_ready;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
            total++;
            if (!done) begin bad++; $display("FAIL stream %0d timeout: got no handshake want one", i); end
        end
        total++;
        if (gcnt - g0 != 16) begin bad++; $display("FAIL stream gauss count: got %0d want 16", gcnt - g0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_eval();
        test_reset_mid();
        test_stream();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (viol != 0) begin bad++; $display("FAIL protocol monitor: got %0d violations want 0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
